// File: rtl/spi_cs_pkg.sv
// Shared types for spi_cs_sequencer: FSM states, the release-all code and the
// code-to-select decoder.
package spi_cs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_RELEASE
    } cs_state_t;

    localparam int CS_RELEASE_ALL = 0;
    localparam int MAX_SEL_W      = 64;

    typedef struct packed {
        logic                 valid;
        logic                 zero;
        logic [MAX_SEL_W-1:0] onehot;
    } cs_dec_t;

    // One-hot layout: slot selects in bits [num_sel-1:0], flash next, MAX3421 last.
    function automatic cs_dec_t cs_decode(input int code, input int num_sel,
                                          input int flash_code, input int max_code);
        cs_dec_t d;
        d = '0;
        if (code == CS_RELEASE_ALL) begin
            d.valid = 1'b1;
            d.zero  = 1'b1;
        end else if (code >= 1 && code <= num_sel) begin
            d.valid  = 1'b1;
            d.onehot = {{(MAX_SEL_W-1){1'b0}}, 1'b1} << (code - 1);
        end else if (code == flash_code) begin
            d.valid  = 1'b1;
            d.onehot = {{(MAX_SEL_W-1){1'b0}}, 1'b1} << num_sel;
        end else if (code == max_code) begin
            d.valid  = 1'b1;
            d.onehot = {{(MAX_SEL_W-1){1'b0}}, 1'b1} << (num_sel + 1);
        end
        return d;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Two-stage synchroniser for a bus of quasi-static asynchronous signals.
module cdc_sync_bus #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_cs_sequencer.sv
// Synchronous SPI chip-select sequencer with guard gap between selects.
// Optional select watchdog enabled by defining SPI_CS_TIMEOUT_EN.
module spi_cs_sequencer
    import spi_cs_pkg::*;
#(
    parameter int                     NUM_SLOTS       = 7,
    parameter int                     NUM_CS_PER_SLOT = 2,
    parameter int                     CS_IN_WIDTH     = 5,
    parameter logic [CS_IN_WIDTH-1:0] FLASH_CODE      = 5'h1d,
    parameter logic [CS_IN_WIDTH-1:0] MAX3421_CODE    = 5'h1e,
    parameter int                     GUARD_CYCLES    = 4,
    parameter int                     TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 cs_ready,
    input  logic [CS_IN_WIDTH-1:0]               cs,
    output logic [NUM_SLOTS*NUM_CS_PER_SLOT-1:0] cs_n,
    output logic                                 flash_cs_n,
    output logic                                 max3421_cs_n,
    output logic                                 busy,
    output logic                                 err_invalid,
    output logic                                 err_timeout
);

    localparam int N     = NUM_SLOTS * NUM_CS_PER_SLOT;
    localparam int SEL_W = N + 2;
    localparam int GW    = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    // Strobe protocol: a rising edge of cs_ready commits cs; there is no
    // back-pressure, the MCU keeps cs stable around the edge.
    logic                   ready_s, ready_d, commit;
    logic [CS_IN_WIDTH-1:0] code_s;
    cs_dec_t                dec;
    logic [SEL_W-1:0]       dec_sel;
    logic                   unused_dec;

    cs_state_t        state;
    logic [GW-1:0]    guard_cnt;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] sel;
    logic             err_inv;

    cdc_sync_bus #(.WIDTH(1)) u_sync_ready (
        .clk    (clk),
        .resetn (resetn),
        .d      (cs_ready),
        .q      (ready_s)
    );

    cdc_sync_bus #(.WIDTH(CS_IN_WIDTH)) u_sync_cs (
        .clk    (clk),
        .resetn (resetn),
        .d      (cs),
        .q      (code_s)
    );

    assign commit     = ready_s & ~ready_d;
    assign dec        = cs_decode(int'(code_s), N, int'(FLASH_CODE), int'(MAX3421_CODE));
    assign dec_sel    = dec.onehot[SEL_W-1:0];
    assign unused_dec = ^dec.onehot[MAX_SEL_W-1:SEL_W];

`ifdef SPI_CS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_to;
    assign err_timeout = err_to;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
    assign err_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            guard_cnt <= GUARD_MAX;
            target    <= '0;
            sel       <= '0;
            ready_d   <= 1'b0;
            err_inv   <= 1'b0;
`ifdef SPI_CS_TIMEOUT_EN
            wd_cnt    <= '0;
            err_to    <= 1'b0;
`endif
        end else begin
            ready_d <= ready_s;
            if (guard_cnt != GUARD_MAX) guard_cnt <= guard_cnt + 1'b1;
            if (commit && dec.zero) begin
                err_inv <= 1'b0;
`ifdef SPI_CS_TIMEOUT_EN
                err_to  <= 1'b0;
`endif
            end
            if (commit && !dec.valid) err_inv <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (commit && dec.valid && !dec.zero) begin
                        target <= dec_sel;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP, ST_RELEASE: begin
                    if (commit && (dec.zero || !dec.valid)) begin
                        target    <= '0;
                        guard_cnt <= '0;
                        state     <= ST_RELEASE;
                    end else if (state == ST_RELEASE) begin
                        if (commit) target <= dec_sel;
                        state <= (commit || target != '0) ? ST_SETUP : ST_IDLE;
                    end else if (guard_cnt >= GUARD_LAST) begin
                        // Counter hits GUARD_CYCLES on this edge: gap is complete.
                        sel    <= commit ? dec_sel : target;
                        target <= commit ? dec_sel : target;
                        state  <= ST_ACTIVE;
`ifdef SPI_CS_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end else if (commit) begin
                        target <= dec_sel;
                    end
                end
                ST_ACTIVE: begin
                    if (commit) begin
`ifdef SPI_CS_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                        if (dec.zero || !dec.valid || dec_sel != sel) begin
                            sel       <= '0;
                            guard_cnt <= '0;
                            target    <= (dec.valid && !dec.zero) ? dec_sel : '0;
                            state     <= ST_RELEASE;
                        end
                    end
`ifdef SPI_CS_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        sel       <= '0;
                        target    <= '0;
                        guard_cnt <= '0;
                        err_to    <= 1'b1;
                        state     <= ST_RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cs_n         = ~sel[N-1:0];
    assign flash_cs_n   = ~sel[N];
    assign max3421_cs_n = ~sel[N+1];
    assign busy         = (state != ST_IDLE);
    assign err_invalid  = err_inv;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer: vector table plus edge-exact sequences.
// Edge E1 is the first rising clk edge that samples cs_ready high.
module tb_spi_cs_sequencer;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cs_ready = 1'b0;
    logic [4:0]  cs = 5'h00;
    logic [13:0] cs_n;
    logic        flash_cs_n, max3421_cs_n, busy, err_invalid, err_timeout;

    int checks = 0;
    int errors = 0;
    int multi_low_cnt = 0;

    always #5 clk = ~clk;

    spi_cs_sequencer #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cs_ready     (cs_ready),
        .cs           (cs),
        .cs_n         (cs_n),
        .flash_cs_n   (flash_cs_n),
        .max3421_cs_n (max3421_cs_n),
        .busy         (busy),
        .err_invalid  (err_invalid),
        .err_timeout  (err_timeout)
    );

    typedef struct {
        logic [4:0]  code;
        logic [13:0] cs_n;
        logic        flash;
        logic        max;
        logic        busy;
        logic        inv;
    } vec_t;

    vec_t vecs[13];

    always @(negedge clk) begin
        if (resetn && $countones(~{cs_n, flash_cs_n, max3421_cs_n}) > 1)
            multi_low_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [13:0] e_cs_n, input logic e_f,
                              input logic e_m, input logic e_busy, input logic e_inv);
        check({tag, ".cs_n"}, 32'(cs_n), 32'(e_cs_n));
        check({tag, ".flash_cs_n"}, 32'(flash_cs_n), 32'(e_f));
        check({tag, ".max3421_cs_n"}, 32'(max3421_cs_n), 32'(e_m));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".err_invalid"}, 32'(err_invalid), 32'(e_inv));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_strobe(input logic [4:0] code);
        cs = code;
        repeat (3) @(negedge clk);
        cs_ready = 1'b1;
    endtask

    task automatic drop_strobe();
        @(negedge clk);
        cs_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic commit_settle(input logic [4:0] code);
        raise_strobe(code);
        repeat (5) @(negedge clk);
        cs_ready = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int hi;
        vecs[0]  = '{5'h03, 14'h3ffb, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{5'h00, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{5'h14, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{5'h00, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{5'h1d, 14'h3fff, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{5'h1e, 14'h3fff, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{5'h0e, 14'h1fff, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{5'h0e, 14'h1fff, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{5'h1f, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{5'h00, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{5'h07, 14'h3fbf, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{5'h0f, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{5'h00, 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_outs("reset", 14'h3fff, 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset.err_timeout", 32'(err_timeout), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Commit latency: low on E4; release latency: high on E3
        raise_strobe(5'h03);
        step(); step(); step();
        check("lat.e3_cs_n", 32'(cs_n), 32'h3fff);
        step();
        check("lat.e4_cs_n", 32'(cs_n), 32'h3ffb);
        check("lat.e4_busy", 32'(busy), 32'd1);
        drop_strobe();
        raise_strobe(5'h00);
        step(); step();
        check("rel.e2_cs_n", 32'(cs_n), 32'h3ffb);
        step();
        check("rel.e3_cs_n", 32'(cs_n), 32'h3fff);
        step();
        check("rel.e4_busy", 32'(busy), 32'd0);
        drop_strobe();

        // Table of steady-state responses
        for (int i = 0; i < 13; i++) begin
            commit_settle(vecs[i].code);
            check_outs($sformatf("vec%0d", i), vecs[i].cs_n, vecs[i].flash, vecs[i].max,
                       vecs[i].busy, vecs[i].inv);
        end

        // Slot switch 01 -> 0e: exactly 4 all-high cycles
        commit_settle(5'h01);
        raise_strobe(5'h0e);
        step(); step();
        check("sw.e2_cs_n", 32'(cs_n), 32'h3ffe);
        hi = 0;
        for (int e = 3; e <= 6; e++) begin
            step();
            if (cs_n == 14'h3fff && flash_cs_n && max3421_cs_n) hi++;
        end
        check("sw.gap_high_cycles", 32'(hi), 32'd4);
        step();
        check("sw.e7_cs_n", 32'(cs_n), 32'h1fff);
        drop_strobe();
        commit_settle(5'h00);

        // Flash -> MAX3421 switch
        commit_settle(5'h1d);
        check("fm.flash_low", 32'(flash_cs_n), 32'd0);
        raise_strobe(5'h1e);
        step(); step();
        check("fm.e2_flash", 32'(flash_cs_n), 32'd0);
        step();
        check("fm.e3_flash", 32'(flash_cs_n), 32'd1);
        check("fm.e3_max", 32'(max3421_cs_n), 32'd1);
        step(); step(); step();
        check("fm.e6_max", 32'(max3421_cs_n), 32'd1);
        step();
        check("fm.e7_max", 32'(max3421_cs_n), 32'd0);
        drop_strobe();
        commit_settle(5'h00);

        // Abandoned select
        raise_strobe(5'h07);
        step(); step(); step(); step();
        check("wd.e4_cs_n", 32'(cs_n), 32'h3fbf);
`ifdef SPI_CS_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            step();
            if (i == 3) cs_ready = 1'b0;
        end
        check("wd.before_cs_n", 32'(cs_n), 32'h3fbf);
        check("wd.before_err_timeout", 32'(err_timeout), 32'd0);
        step();
        check("wd.fire_cs_n", 32'(cs_n), 32'h3fff);
        check("wd.fire_err_timeout", 32'(err_timeout), 32'd1);
        step(); step();
        check("wd.idle_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        commit_settle(5'h00);
        check("wd.clear_err_timeout", 32'(err_timeout), 32'd0);
`else
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 3) cs_ready = 1'b0;
        end
        check("hold.cs_n", 32'(cs_n), 32'h3fbf);
        check("hold.busy", 32'(busy), 32'd1);
        check("hold.err_timeout", 32'(err_timeout), 32'd0);
        repeat (3) @(negedge clk);
        commit_settle(5'h00);
        check("hold.release_cs_n", 32'(cs_n), 32'h3fff);
`endif

        // Reset mid-transfer with a pending switch
        commit_settle(5'h0a);
        raise_strobe(5'h05);
        step(); step();
        check("rst.e2_cs_n", 32'(cs_n), 32'h3dff);
        resetn = 1'b0;
        #1;
        check("rst.async_cs_n", 32'(cs_n), 32'h3fff);
        check("rst.async_busy", 32'(busy), 32'd0);
        cs_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        raise_strobe(5'h02);
        step(); step(); step();
        check("rst.e3_cs_n", 32'(cs_n), 32'h3fff);
        step();
        check("rst.e4_cs_n", 32'(cs_n), 32'h3ffd);
        drop_strobe();
        commit_settle(5'h00);

        check("never_two_low", 32'(multi_low_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cs_sequencer.md
# spi_cs_sequencer

Parametrised, clock-synchronous successor to the slot chip-select decoder. It sits between the MCU's encoded chip-select bus and the card-slot / flash / MAX3421 SPI select pins. Every strobe is synchronised into `clk` and at most one select is driven low at a time. A guaranteed all-high guard gap separates consecutive selects, and an optional watchdog releases a select the MCU has abandoned.

## Interface
- `NUM_SLOTS`, 7, number of card slots
- `NUM_CS_PER_SLOT`, 2, selects per slot
- `CS_IN_WIDTH`, 5, width of encoded code bus
- `FLASH_CODE`, 5'h1d, code selecting flash
- `MAX3421_CODE`, 5'h1e, code selecting MAX3421
- `GUARD_CYCLES`, 4, minimum all-high `clk` cycles between two selects (≥1)
- `TIMEOUT_CYCLES`, 1_000_000, watchdog limit in `clk` cycles (≥2)
- `clk` in 1 — 100 MHz system clock
- `resetn` in 1 — reset resetn, asynchronous, active-low
- `cs_ready` in 1 — asynchronous strobe from MCU; rising edge commits `cs`
- `cs` in `CS_IN_WIDTH` — encoded select code, asynchronous
- `cs_n` out `NUM_SLOTS*NUM_CS_PER_SLOT` — slot selects, active-low
- `flash_cs_n` out 1 — flash select, active-low
- `max3421_cs_n` out 1 — MAX3421 select, active-low
- `busy` out 1 — high in any state other than IDLE
- `err_invalid` out 1 — sticky, unmapped code received
- `err_timeout` out 1 — sticky, watchdog fired

## Operation
- `cs_ready` and `cs` each pass through a 2-flop synchroniser. The MCU holds `cs` stable ≥3 `clk` before and after the `cs_ready` rising edge.
- A rising edge of the synchronised strobe (third flop compare) is a *commit*. The code is latched on the commit cycle. Falling edges are ignored.
- Code map:
  - 0 → release all.
  - k in 1..N, where N = `NUM_SLOTS*NUM_CS_PER_SLOT` → `cs_n[k-1]`.
  - `FLASH_CODE` → flash.
  - `MAX3421_CODE` → MAX3421.
  - Any other code → invalid.
- FSM states and transitions:
  - **IDLE**: all selects high.
    - Valid select commit → SETUP.
    - Code 0 → stay in IDLE.
    - Invalid code → set `err_invalid`, stay in IDLE.
  - **SETUP**: wait until the guard counter reaches `GUARD_CYCLES`, then drive the target select low → ACTIVE.
  - **ACTIVE**: exactly one select low.
    - Commit of the same code → no change.
    - Commit of a different valid code → release, latch the new target → RELEASE.
    - Code 0 → RELEASE with no target.
    - Invalid code → release, set `err_invalid` → RELEASE with no target.
  - **RELEASE**: all high, guard counter restarted → SETUP if a target is pending, else IDLE.
- The guard counter restarts on every release and saturates at `GUARD_CYCLES`.
- A commit arriving in SETUP or RELEASE replaces the pending target, with code-0 and invalid-code handling as in ACTIVE. It never shortens the guard gap.
- `err_invalid` and `err_timeout` clear only on a code-0 commit or on reset.
- Selects are registered outputs, glitch-free. No two selects are ever low in the same cycle.

## Timing
- Reset value of every output: `cs_n` all ones, `flash_cs_n` = 1, `max3421_cs_n` = 1, `busy` = 0, `err_invalid` = 0, `err_timeout` = 0. All state registers are cleared.
- Commit latency: the select goes low on the 4th `clk` edge after the first edge that samples `cs_ready` high, provided the guard is already satisfied. Otherwise it goes low once the guard count completes.
- Switch A→B: A high on commit+2 edges, B low exactly `GUARD_CYCLES` edges after A rises.
- Release latency (code 0): the select goes high on the 3rd edge after the commit edge.
- Reset asserted mid-transfer: all selects go high asynchronously. After reset, the FSM is in IDLE and the guard counter is saturated, so the first select is not delayed.

## Configuration
- `SPI_CS_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter runs in ACTIVE and resets on any commit.
  - When it reaches `TIMEOUT_CYCLES`, the select is released, `err_timeout` is set, and the FSM goes RELEASE → IDLE.
- Undefined: no counter exists, `err_timeout` is tied to 0, and ACTIVE is held indefinitely.

## Structure
- Package `spi_cs_pkg`:
  - FSM state enum (IDLE, SETUP, ACTIVE, RELEASE).
  - Code constant for release-all (0).
  - `function` mapping a code to a one-hot vector plus valid flag.
- Sub-module `cdc_sync_bus` (parametrised width, 2 stages) is instantiated for `cs_ready` and `cs`.

## Test plan
- Reset, commit code 5'h03 → `cs_n` = 14'h3ffb on the 4th edge, `busy` = 1. Then commit 0 → `cs_n` = 14'h3fff, `busy` = 0.
- Commit 5'h01, then 5'h0e → `cs_n[0]` rises, exactly 4 all-high cycles, then `cs_n[13]` falls. Checker confirms there is never more than one low.
- Commit 5'h1d then 5'h1e → `flash_cs_n` low, then released, then after a 4-cycle guard `max3421_cs_n` low.
- Commit 5'h14 in IDLE → all selects high, `err_invalid` = 1. Commit 0 → `err_invalid` = 0.
- With `SPI_CS_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50: commit 5'h07, no further strobe → `cs_n[6]` high 50 cycles after assertion, `err_timeout` = 1, `busy` returns to 0.
- Assert `resetn` low while `cs_n[9]` is low and a switch is pending → all selects high immediately. After release, commit 5'h02 asserts with no extra guard delay.
